// File: rtl/noc_in_port.sv
// Router input port: flit FIFO, XY route on the head flit, single-output request,
// wormhole streaming to the crossbar. Optional sticky error flag: NOC_IN_PORT_ERR_EN.
module noc_in_port #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int PORT_ID = 0,
    parameter int COORD_W = 2,
    parameter int CUR_X   = 0,
    parameter int CUR_Y   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic              req_n_o,
    output logic              req_s_o,
    output logic              req_e_o,
    output logic              req_w_o,
    output logic              req_l_o,
    output logic              en_o,
    input  logic [2:0]        grant_n_i,
    input  logic [2:0]        grant_s_i,
    input  logic [2:0]        grant_e_i,
    input  logic [2:0]        grant_w_i,
    input  logic [2:0]        grant_l_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i
`ifdef NOC_IN_PORT_ERR_EN
    ,
    output logic              err_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] OUT_N = 3'd0;
    localparam logic [2:0] OUT_S = 3'd1;
    localparam logic [2:0] OUT_E = 3'd2;
    localparam logic [2:0] OUT_W = 3'd3;
    localparam logic [2:0] OUT_L = 3'd4;

    localparam logic [2:0]         PID    = 3'(PORT_ID);
    localparam logic [COORD_W-1:0] CX     = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CY     = COORD_W'(CUR_Y);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Flit FIFO
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] front;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign ready_o = ~full;
    assign push    = valid_i & ~full;
    assign front   = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Type bits: [DATA_W-2] set for head/single, [DATA_W-1] set for tail/single.
    logic front_is_head;
    logic front_is_tail;
    assign front_is_head = front[DATA_W-2];
    assign front_is_tail = front[DATA_W-1];

    // ------------------------------------------------------------------
    // XY route of the flit at the FIFO front
    // ------------------------------------------------------------------
    logic [COORD_W-1:0] dest_x;
    logic [COORD_W-1:0] dest_y;
    logic [2:0]         route;

    assign dest_x = front[COORD_W-1:0];
    assign dest_y = front[2*COORD_W-1:COORD_W];

    always_comb begin
        route = OUT_L;
        if (dest_x > CX) begin
            route = OUT_E;
        end else if (dest_x < CX) begin
            route = OUT_W;
        end else if (dest_y > CY) begin
            route = OUT_N;
        end else if (dest_y < CY) begin
            route = OUT_S;
        end
    end

    // ------------------------------------------------------------------
    // Request / grant / transfer FSM
    // ------------------------------------------------------------------
    state_t     state_q;
    state_t     state_d;
    logic [2:0] out_sel_q;
    logic [2:0] out_sel_d;
    logic [2:0] grant_sel;
    logic       fifo_valid;

    assign fifo_valid = ~empty;

    always_comb begin
        grant_sel = 3'b111;
        case (out_sel_q)
            OUT_N:   grant_sel = grant_n_i;
            OUT_S:   grant_sel = grant_s_i;
            OUT_E:   grant_sel = grant_e_i;
            OUT_W:   grant_sel = grant_w_i;
            OUT_L:   grant_sel = grant_l_i;
            default: grant_sel = 3'b111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            out_sel_q <= OUT_L;
        end else begin
            state_q   <= state_d;
            out_sel_q <= out_sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        out_sel_d = out_sel_q;
        pop       = 1'b0;
        valid_o   = 1'b0;
        en_o      = 1'b0;
        case (state_q)
            IDLE: begin
                en_o = 1'b1;
                if (fifo_valid) begin
                    if (front_is_head) begin
                        out_sel_d = route;
                        state_d   = REQ;
                    end else begin
                        // Orphan body/tail without a head: drop it.
                        pop = 1'b1;
                    end
                end
            end
            REQ: begin
                if (grant_sel == PID) begin
                    state_d = XFER;
                end
            end
            XFER: begin
                valid_o = fifo_valid;
                pop     = fifo_valid & ready_i;
                if (fifo_valid && ready_i && front_is_tail) begin
                    en_o    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign data_o = front;

    // Request held from REQ through the tail pop of the packet.
    logic       req_active;
    logic [4:0] req_vec;

    assign req_active = (state_q == REQ) || (state_q == XFER);

    for (genvar gi = 0; gi < 5; gi++) begin : g_req
        assign req_vec[gi] = req_active & (out_sel_q == 3'(gi));
    end

    assign req_n_o = req_vec[OUT_N];
    assign req_s_o = req_vec[OUT_S];
    assign req_e_o = req_vec[OUT_E];
    assign req_w_o = req_vec[OUT_W];
    assign req_l_o = req_vec[OUT_L];

`ifdef NOC_IN_PORT_ERR_EN
    // ------------------------------------------------------------------
    // Sticky protocol error: orphan flit dropped, or new head arriving
    // before the previous packet's tail has been pushed.
    // ------------------------------------------------------------------
    logic err_q;
    logic in_pkt_q;
    logic discard;
    logic push_is_head;
    logic push_is_tail;

    assign discard      = (state_q == IDLE) & pop;
    assign push_is_head = push & data_i[DATA_W-2];
    assign push_is_tail = push & data_i[DATA_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q    <= 1'b0;
            in_pkt_q <= 1'b0;
        end else begin
            if (discard || (push_is_head && in_pkt_q)) begin
                err_q <= 1'b1;
            end
            if (push_is_tail) begin
                in_pkt_q <= 1'b0;
            end else if (push_is_head) begin
                in_pkt_q <= 1'b1;
            end
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_noc_in_port.sv
// Directed + randomized bench for noc_in_port at CUR=(1,1), PORT_ID=2, DEPTH=4,
// scoreboarding crossbar output against the flits pushed upstream.
module tb_noc_in_port;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int PID   = 2;
    localparam int CWD   = 2;
    localparam int CX    = 1;
    localparam int CY    = 1;

    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_HEAD   = 2'b01;
    localparam logic [1:0] T_TAIL   = 2'b10;
    localparam logic [1:0] T_SINGLE = 2'b11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic          req_n_o, req_s_o, req_e_o, req_w_o, req_l_o;
    logic          en_o;
    logic [2:0]    grant_n_i = 3'b111;
    logic [2:0]    grant_s_i = 3'b111;
    logic [2:0]    grant_e_i = 3'b111;
    logic [2:0]    grant_w_i = 3'b111;
    logic [2:0]    grant_l_i = 3'b111;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
`ifdef NOC_IN_PORT_ERR_EN
    logic          err_o;
`endif

    noc_in_port #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .PORT_ID(PID),
        .COORD_W(CWD),
        .CUR_X  (CX),
        .CUR_Y  (CY)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .data_i   (data_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .req_n_o  (req_n_o),
        .req_s_o  (req_s_o),
        .req_e_o  (req_e_o),
        .req_w_o  (req_w_o),
        .req_l_o  (req_l_o),
        .en_o     (en_o),
        .grant_n_i(grant_n_i),
        .grant_s_i(grant_s_i),
        .grant_e_i(grant_e_i),
        .grant_w_i(grant_w_i),
        .grant_l_i(grant_l_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
`ifdef NOC_IN_PORT_ERR_EN
        .err_o    (err_o),
`endif
        .ready_i  (ready_i)
    );

    always #5 clk = ~clk;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] exp_q[$];
    bit            push_discard = 1'b0;
    bit            last_pushed  = 1'b0;
    logic [4:0]    req;

    assign req = {req_l_o, req_w_o, req_e_o, req_s_o, req_n_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output order 0 N, 1 S, 2 E, 3 W, 4 L.
    function automatic int route_of(input int dx, input int dy);
        if (dx > CX) return 2;
        if (dx < CX) return 3;
        if (dy > CY) return 0;
        if (dy < CY) return 1;
        return 4;
    endfunction

    function automatic logic [4:0] onehot(input int r);
        logic [4:0] v;
        v = 5'b00001;
        return v << r;
    endfunction

    function automatic logic [DW-1:0] mk(input logic [1:0] t, input int dx, input int dy);
        logic [DW-1:0] f;
        f            = DW'($urandom);
        f[DW-1:DW-2] = t;
        f[1:0]       = dx[1:0];
        f[3:2]       = dy[1:0];
        return f;
    endfunction

    task automatic set_grant(input int p, input logic [2:0] v);
        grant_n_i = 3'b111;
        grant_s_i = 3'b111;
        grant_e_i = 3'b111;
        grant_w_i = 3'b111;
        grant_l_i = 3'b111;
        case (p)
            0: grant_n_i = v;
            1: grant_s_i = v;
            2: grant_e_i = v;
            3: grant_w_i = v;
            default: grant_l_i = v;
        endcase
    endtask

    // One clock: record accepted pushes, score crossbar pops, then step.
    task automatic cyc();
        logic [DW-1:0] e;
        last_pushed = 1'b0;
        if (valid_i && ready_o) begin
            last_pushed = 1'b1;
            if (!push_discard) exp_q.push_back(data_i);
        end
        if (valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 32'(valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("data_o_pop", data_o, e);
                $display("pop data=%08h", e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [DW-1:0] f);
        valid_i = 1'b1;
        data_i  = f;
        #1;
        cyc();
        valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] f, x;
        logic [DW-1:0] pk[4];
        bit            pat[5];
        int            idx, len, dx, dy, r;

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_req", req, 5'b0);
        chk("rst_valid", valid_o, 1'b0);
        chk("rst_en", en_o, 1'b1);
        chk("rst_ready", ready_o, 1'b1);
`ifdef NOC_IN_PORT_ERR_EN
        chk("rst_err", err_o, 1'b0);
`endif

        // ---------------- single flit to E ----------------
        ready_i = 1'b1;
        f = mk(T_SINGLE, 2, 1);
        push1(f);
        #1;
        chk("t1_idle_req", req, 5'b0);
        chk("t1_idle_valid", valid_o, 1'b0);
        cyc(); #1;
        chk("t1_req_e", req, 5'b00100);
        chk("t1_req_en", en_o, 1'b0);
        chk("t1_req_valid", valid_o, 1'b0);
        cyc(); #1;
        chk("t1_req_hold", req, 5'b00100);
        set_grant(2, 3'd2);
        cyc();
        set_grant(2, 3'b111);
        #1;
        chk("t1_valid", valid_o, 1'b1);
        chk("t1_data", data_o, f);
        chk("t1_en_pop", en_o, 1'b1);
        cyc(); #1;
        chk("t1_req_drop", req, 5'b0);
        chk("t1_valid_drop", valid_o, 1'b0);
        chk("t1_en_idle", en_o, 1'b1);

        // ---------------- 4-flit packet to N, ready toggled ----------------
        ready_i = 1'b0;
        pk[0] = mk(T_HEAD, 1, 3);
        pk[1] = mk(T_BODY, 0, 0);
        pk[2] = mk(T_BODY, 0, 0);
        pk[3] = mk(T_TAIL, 0, 0);
        for (int i = 0; i < 4; i++) push1(pk[i]);
        #1;
        chk("t2_req_n", req, 5'b00001);
        chk("t2_req_en", en_o, 1'b0);
        set_grant(0, 3'd2);
        cyc();
        set_grant(0, 3'b111);
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        idx = 0;
        for (int k = 0; k < 5; k++) begin
            ready_i = pat[k];
            #1;
            chk("t2_valid", valid_o, 1'b1);
            chk("t2_data", data_o, pk[idx]);
            chk("t2_req_hold", req, 5'b00001);
            chk("t2_en", en_o, 32'(pat[k] && idx == 3));
            cyc();
            if (pat[k]) idx++;
        end
        #1;
        chk("t2_req_drop", req, 5'b0);
        chk("t2_en_idle", en_o, 1'b1);
        chk("t2_drained", exp_q.size(), 0);

        // ---------------- fill to full, foreign grant on L ----------------
        ready_i = 1'b0;
        pk[0] = mk(T_HEAD, 1, 1);
        pk[1] = mk(T_BODY, 0, 0);
        pk[2] = mk(T_BODY, 0, 0);
        pk[3] = mk(T_TAIL, 0, 0);
        x     = mk(T_SINGLE, 0, 1);
        for (int i = 0; i < 4; i++) begin
            valid_i = 1'b1;
            data_i  = pk[i];
            #1;
            chk("t3_ready_before", ready_o, 1'b1);
            cyc();
        end
        data_i = x;
        #1;
        chk("t3_full", ready_o, 1'b0);
        set_grant(4, 3'd3);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_req_l", req, 5'b10000);
            chk("t4_valid", valid_o, 1'b0);
            chk("t4_en", en_o, 1'b0);
            chk("t3_held", ready_o, 1'b0);
            cyc();
        end
        set_grant(4, 3'd2);
        cyc();
        set_grant(4, 3'b111);
        ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_valid", valid_o, 1'b1);
            chk("t3_data", data_o, pk[k]);
            chk("t3_en", en_o, 32'(k == 3));
            cyc();
            if (last_pushed) valid_i = 1'b0;
        end
        #1;
        chk("gap1_valid", valid_o, 1'b0);
        chk("gap1_req", req, 5'b0);
        cyc(); #1;
        chk("gap2_valid", valid_o, 1'b0);
        chk("gap2_req_w", req, 5'b01000);
        set_grant(3, 3'd2);
        cyc();
        set_grant(3, 3'b111);
        #1;
        chk("t3_fifth_data", data_o, x);
        chk("t3_fifth_en", en_o, 1'b1);
        cyc(); #1;
        chk("t3_drained", exp_q.size(), 0);

        // ---------------- orphan body in IDLE ----------------
        push_discard = 1'b1;
        push1(mk(T_BODY, 2, 2));
        push_discard = 1'b0;
        #1;
        chk("t5_req", req, 5'b0);
        chk("t5_en", en_o, 1'b1);
        cyc(); #1;
        chk("t5_req_after", req, 5'b0);
`ifdef NOC_IN_PORT_ERR_EN
        chk("t5_err", err_o, 1'b1);
`endif
        f = mk(T_SINGLE, 1, 0);
        push1(f);
        #1;
        chk("t5_next_idle", req, 5'b0);
        cyc(); #1;
        chk("t5_next_req_s", req, 5'b00010);
        set_grant(1, 3'd2);
        cyc();
        set_grant(1, 3'b111);
        #1;
        chk("t5_next_data", data_o, f);
        cyc();
`ifdef NOC_IN_PORT_ERR_EN
        chk("t5_err_sticky", err_o, 1'b1);
`endif

        // ---------------- reset mid-XFER ----------------
        ready_i = 1'b0;
        push1(mk(T_HEAD, 2, 1));
        push1(mk(T_BODY, 0, 0));
        push1(mk(T_BODY, 0, 0));
        set_grant(2, 3'd2);
        cyc();
        set_grant(2, 3'b111);
        ready_i = 1'b1;
        #1;
        chk("t6_valid", valid_o, 1'b1);
        cyc();
        ready_i = 1'b0;
        #1;
        chk("t6_buffered", valid_o, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_req", req, 5'b0);
        chk("t6_valid_rst", valid_o, 1'b0);
        chk("t6_en", en_o, 1'b1);
        chk("t6_ready", ready_o, 1'b1);
`ifdef NOC_IN_PORT_ERR_EN
        chk("t6_err", err_o, 1'b0);
`endif
        cyc(); #1;
        chk("t6_empty_req", req, 5'b0);
        chk("t6_empty_valid", valid_o, 1'b0);

        // ---------------- randomized packets ----------------
        for (int p = 0; p < 12; p++) begin
            len = $urandom_range(1, 4);
            dx  = $urandom_range(0, 3);
            dy  = $urandom_range(0, 3);
            r   = route_of(dx, dy);
            ready_i = 1'b0;
            for (int i = 0; i < len; i++) begin
                if (len == 1)           f = mk(T_SINGLE, dx, dy);
                else if (i == 0)        f = mk(T_HEAD, dx, dy);
                else if (i == len - 1)  f = mk(T_TAIL, 0, 0);
                else                    f = mk(T_BODY, 0, 0);
                push1(f);
            end
            for (int k = 0; k < 8; k++) begin
                #1;
                if (req != 5'b0) break;
                cyc();
            end
            chk("rnd_req", req, onehot(r));
            repeat ($urandom_range(0, 2)) begin
                #1;
                chk("rnd_wait_valid", valid_o, 1'b0);
                chk("rnd_wait_en", en_o, 1'b0);
                cyc();
            end
            set_grant(r, 3'd2);
            cyc();
            set_grant(r, 3'b111);
            for (int k = 0; k < 40 && exp_q.size() > 0; k++) begin
                ready_i = 1'($urandom_range(0, 1));
                #1;
                chk("rnd_valid", valid_o, 1'b1);
                chk("rnd_req_hold", req, onehot(r));
                chk("rnd_en", en_o, 32'(ready_i && exp_q.size() == 1));
                cyc();
            end
            chk("rnd_drained", exp_q.size(), 0);
            #1;
            chk("rnd_req_drop", req, 5'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_in_port.md
Name: noc_in_port

Overview:
- Router input-port controller: the requester side of the five per-output round-robin arbiters.
- Buffers incoming flits in a small FIFO and computes the XY route from the head flit.
- Raises a request to exactly one output arbiter, watches that arbiter's grant index for its own port ID, then streams the wormhole packet to the crossbar.
- Drives the per-input release enable that the arbiters use to hold or advance their grants.

Parameters:
- DATA_W, 32: flit width; bits [DATA_W-1:DATA_W-2] hold the flit type: 01 head, 00 body, 10 tail, 11 single (head+tail).
- DEPTH, 4: FIFO depth in flits; must be a power of 2 and at least 2.
- PORT_ID, 0: index of this input as seen by the arbiters: 0 N, 1 S, 2 E, 3 W, 4 L.
- COORD_W, 2: width of each X/Y coordinate field.
- CUR_X, 0: this router's X coordinate.
- CUR_Y, 0: this router's Y coordinate.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- data_i  in  DATA_W  upstream flit
- valid_i  in  1  upstream flit valid
- ready_o  out  1  FIFO can accept a flit (~full)
- req_n_o, req_s_o, req_e_o, req_w_o, req_l_o  out  1 each  request to the N/S/E/W/L output arbiter
- en_o  out  1  release enable to the arbiters: high = not locked mid-packet
- grant_n_i, grant_s_i, grant_e_i, grant_w_i, grant_l_i  in  3 each  grant index from each output arbiter; 3'b111 = none
- data_o  out  DATA_W  flit to the crossbar
- valid_o  out  1  data_o valid
- ready_i  in  1  downstream can accept this cycle

Behaviour:
- Head flit address fields: dest X in [COORD_W-1:0], dest Y in [2*COORD_W-1:COORD_W].
- XY route, unsigned compare, X first:
  - dx>CUR_X -> E; dx<CUR_X -> W
  - else dy>CUR_Y -> N; dy<CUR_Y -> S
  - else L
- FIFO:
  - push = valid_i & ready_o.
  - pop as defined under XFER.
  - Push and pop in the same cycle are both allowed; occupancy is unchanged.
  - When full, ready_o=0 and the flit is not written; there is no bypass.
  - Pointers wrap modulo DEPTH; a separate count of width clog2(DEPTH)+1 distinguishes full from empty.
- FSM states IDLE, REQ, XFER:
  - IDLE, FIFO empty: stay.
  - IDLE, front is head or single: latch out_sel from its route; go to REQ next cycle.
  - IDLE, front is body or tail (malformed): pop and discard, stay IDLE.
  - REQ: assert req_<out_sel>_o=1. When grant_<out_sel>_i==PORT_ID in a cycle, go to XFER next cycle. Otherwise stay; there is no timeout.
  - XFER: valid_o = ~empty, and data_o = FIFO front (combinational from the FIFO). pop = valid_o & ready_i. req_<out_sel>_o stays high for the whole packet.
  - XFER exit on popping tail or single: next state is IDLE, and req drops the cycle after that pop.
- en_o:
  - 0 in REQ and XFER.
  - 1 in IDLE.
  - 1 in XFER in the cycle the tail/single flit is popped, so the arbiter may re-arbitrate.
- Empty mid-packet in XFER: valid_o=0, stay XFER, req held, en_o=0.
- ready_i=0: hold data_o/valid_o stable; no pop.
- Never more than one req_*_o high; all low in IDLE.
- Back-to-back packets: minimum 2 idle cycles between the tail pop and the next head's first pop (IDLE->REQ->grant).
- Reset (any state, including mid-packet): FSM=IDLE, FIFO emptied, all req=0, valid_o=0, en_o=1, ready_o=1 in the cycle after reset is sampled. data_o is don't-care while valid_o=0.

Optional Feature:
- Macro: NOC_IN_PORT_ERR_EN.
- Defined:
  - Adds output err_o (1 bit), reset to 0.
  - err_o sets sticky when a malformed flit is discarded in IDLE.
  - err_o also sets when a head or single flit is pushed while the current packet's tail is still un-pushed.
  - err_o clears only on rst.
- Undefined: no err_o port; malformed flits are discarded silently.

Test Plan:
- CUR=(1,1), PORT_ID=2. Push single flit with dest (2,1); grant_e_i=3'b010 two cycles after req_e_o rises -> req_e_o=1 only, valid_o=1 the cycle after the grant, en_o=1 on the pop cycle, req_e_o=0 the next cycle.
- Head dest (1,3) + 2 body + tail, ready_i toggled 1,0,1,1,1 -> req_n_o for the whole packet, 4 flits out in order, en_o=0 until the tail pop.
- DEPTH=4, ready_i=0, push 5 flits -> ready_o=0 after the 4th push; the 5th flit is held upstream; count=4.
- grant_l_i=3'b011 (another port) for 5 cycles with dest=(CUR_X,CUR_Y) -> stay REQ, no pop, valid_o=0, en_o=0.
- Body flit at the front while IDLE -> popped in 1 cycle, no req raised. With NOC_IN_PORT_ERR_EN defined, err_o=1 until rst.
- Assert rst for 1 cycle mid-XFER with 2 flits buffered -> next cycle all req=0, valid_o=0, en_o=1, ready_o=1, FIFO empty.
